// File: rtl/xge_rx_pkt_sink.sv
// rtl/xge_rx_pkt_sink.sv - RX packet sink: framing check, frame length, classification and statistics
// Optional frame sequence-number checking is built when XGE_RX_SINK_SEQ_CHK_EN is defined.
module xge_rx_pkt_sink #(
  parameter int CNT_W   = 32,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25,
  input  logic             enable,
  input  logic             clr_stats,
  input  logic             pkt_rx_avail,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic             pkt_rx_err,
  input  logic [2:0]       pkt_rx_mod,
  input  logic [63:0]      pkt_rx_data,
  output logic             pkt_rx_ren,
  output logic             pkt_done,
  output logic [15:0]      last_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] runt_cnt,
  output logic [CNT_W-1:0] giant_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt, words_fin;
  logic        complete, frm_err;
  logic [3:0]  tail_bytes;
  logic [19:0] len_wide;
  logic [15:0] frame_len;
  logic        unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [15:0] a);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(a);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    words_fin = 16'd1;
    complete  = 1'b0;
    frm_err   = 1'b0;
    if (pkt_rx_val) begin
      case (state)
        IDLE: begin
          if (pkt_rx_sop) begin
            if (pkt_rx_eop) begin
              complete = 1'b1;
            end else begin
              state_nxt = IN_PKT;
              wcnt_nxt  = 16'd1;
            end
          end else begin
            frm_err = 1'b1;
          end
        end
        IN_PKT: begin
          // A SOP without a prior EOP abandons the open frame and starts a new one.
          if (pkt_rx_sop) begin
            frm_err  = 1'b1;
            wcnt_nxt = 16'd1;
            if (pkt_rx_eop) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            wcnt_nxt = (&wcnt) ? wcnt : wcnt + 16'd1;
            if (pkt_rx_eop) begin
              complete  = 1'b1;
              words_fin = wcnt_nxt;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tail_bytes = (pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
  assign len_wide   = {1'b0, words_fin, 3'b000} - 20'd8 + {16'd0, tail_bytes};
  assign frame_len  = (|len_wide[19:16]) ? 16'hFFFF : len_wide[15:0];
  assign unused_bits = ^pkt_rx_data;

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state       <= IDLE;
      wcnt        <= 16'd0;
      pkt_rx_ren  <= 1'b0;
      pkt_done    <= 1'b0;
      last_len    <= 16'd0;
      good_cnt    <= '0;
      err_cnt     <= '0;
      runt_cnt    <= '0;
      giant_cnt   <= '0;
      frm_err_cnt <= '0;
      byte_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      // Looking at the next state lets ren drop right after the EOP when enable is low.
      pkt_rx_ren <= (enable & pkt_rx_avail) | (state_nxt == IN_PKT);
      pkt_done   <= complete;
      if (complete) last_len <= frame_len;
      if (clr_stats) begin
        good_cnt    <= '0;
        err_cnt     <= '0;
        runt_cnt    <= '0;
        giant_cnt   <= '0;
        frm_err_cnt <= '0;
        byte_cnt    <= '0;
      end else begin
        if (frm_err) frm_err_cnt <= sat_inc(frm_err_cnt);
        if (complete) begin
          byte_cnt <= sat_add(byte_cnt, frame_len);
          if (pkt_rx_err)             err_cnt   <= sat_inc(err_cnt);
          else if (frame_len < MIN_L) runt_cnt  <= sat_inc(runt_cnt);
          else if (frame_len > MAX_L) giant_cnt <= sat_inc(giant_cnt);
          else                        good_cnt  <= sat_inc(good_cnt);
        end
      end
    end
  end

`ifdef XGE_RX_SINK_SEQ_CHK_EN
  logic [31:0] seq_rx, seq_exp, seq_cur;
  logic        seq_valid, second_word, seq_chk;

  assign second_word = pkt_rx_val & (state == IN_PKT) & ~pkt_rx_sop & (wcnt == 16'd1);
  assign seq_cur     = second_word ? pkt_rx_data[31:0] : seq_rx;
  // words_fin >= 2 guarantees word 1 of this very frame was captured.
  assign seq_chk     = complete & (words_fin >= 16'd2);

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      seq_rx      <= 32'd0;
      seq_exp     <= 32'd0;
      seq_valid   <= 1'b0;
      seq_err_cnt <= '0;
    end else begin
      if (second_word) seq_rx <= pkt_rx_data[31:0];
      if (clr_stats) begin
        seq_valid   <= 1'b0;
        seq_err_cnt <= '0;
      end else if (seq_chk) begin
        seq_valid <= 1'b1;
        seq_exp   <= seq_cur + 32'd1;
        if (seq_valid && (seq_cur != seq_exp)) seq_err_cnt <= sat_inc(seq_err_cnt);
      end
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_xge_rx_pkt_sink.sv
// tb/tb_xge_rx_pkt_sink.sv - randomized self-checking bench for xge_rx_pkt_sink
// Frame-level reference model kept as plain integer counters.
`timescale 1ns/1ps
module tb_xge_rx_pkt_sink;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk, reset, enable, clr_stats, avail, val, sop, eop, err;
  logic [2:0]    mod;
  logic [63:0]   data;
  logic          ren, done;
  logic [15:0]   last_len;
  logic [CW-1:0] good_cnt, err_cnt, runt_cnt, giant_cnt, frm_err_cnt, seq_err_cnt, byte_cnt;

  int total = 0, bad = 0, done_seen = 0;
  int e_good, e_err, e_runt, e_giant, e_frm, e_seq, e_bytes, e_last_len, e_done;
  bit s_valid;
  logic [31:0] s_exp, seq_ctr = 32'd100;

  xge_rx_pkt_sink #(.CNT_W(CW), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_156m25(clk), .reset_156m25(reset), .enable(enable), .clr_stats(clr_stats),
    .pkt_rx_avail(avail), .pkt_rx_val(val), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_err(err), .pkt_rx_mod(mod), .pkt_rx_data(data), .pkt_rx_ren(ren),
    .pkt_done(done), .last_len(last_len), .good_cnt(good_cnt), .err_cnt(err_cnt),
    .runt_cnt(runt_cnt), .giant_cnt(giant_cnt), .frm_err_cnt(frm_err_cnt),
    .seq_err_cnt(seq_err_cnt), .byte_cnt(byte_cnt));

  initial clk = 1'b0;
  always #3 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clr();
    e_good = 0; e_err = 0; e_runt = 0; e_giant = 0; e_frm = 0; e_seq = 0; e_bytes = 0;
    s_valid = 1'b0;
  endtask

  task automatic model_frame(input int n, input int m, input bit er, input logic [31:0] seq, input bit clr);
    int len;
    len = 8 * (n - 1) + ((m == 0) ? 8 : m);
    if (len > 65535) len = 65535;
    e_last_len = len;
    e_done++;
    if (clr) begin
      model_clr();
      return;
    end
    e_bytes = sat(e_bytes + len);
    if (er)             e_err   = sat(e_err + 1);
    else if (len < 64)  e_runt  = sat(e_runt + 1);
    else if (len > 1518) e_giant = sat(e_giant + 1);
    else                e_good  = sat(e_good + 1);
`ifdef XGE_RX_SINK_SEQ_CHK_EN
    if (n >= 2) begin
      if (s_valid && seq != s_exp) e_seq = sat(e_seq + 1);
      s_valid = 1'b1;
      s_exp   = seq + 32'd1;
    end
`endif
  endtask

  task automatic drive_word(input bit s, input bit e, input bit r, input logic [2:0] m, input logic [63:0] d);
    val = 1'b1; sop = s; eop = e; err = r; mod = m; data = d;
    @(posedge clk); #1;
    val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = 3'd0;
  endtask

  task automatic idle(input int n);
    val = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int m, input bit er, input logic [31:0] seq, input bit clr_eop);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) d[31:0] = seq;
      if (i == n - 1 && clr_eop) clr_stats = 1'b1;
      drive_word(i == 0, i == n - 1, (i == n - 1) ? er : 1'($urandom),
                 (i == n - 1) ? 3'(m) : 3'($urandom), d);
      clr_stats = 1'b0;
    end
    model_frame(n, m, er, seq, clr_eop);
  endtask

  task automatic do_clr();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    model_clr();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; avail = 1'b1;
    idle(3);
    total++; if (ren !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0d exp=0", ren); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
    total++; if (last_len !== 16'd0) begin bad++; $display("FAIL reset_last_len got=%0d exp=0", last_len); end
    total++; if ({good_cnt, err_cnt, runt_cnt, giant_cnt, frm_err_cnt, seq_err_cnt, byte_cnt} !== '0) begin
      bad++; $display("FAIL reset_counters got=%h exp=0", {good_cnt, err_cnt, runt_cnt, giant_cnt, frm_err_cnt, seq_err_cnt, byte_cnt});
    end
    reset = 1'b0;
    model_clr(); e_last_len = 0; e_done = 0;
    idle(1);
    total++; if (ren !== 1'b1) begin bad++; $display("FAIL post_reset_ren got=%0d exp=1", ren); end
  endtask

  task automatic test_good_frame();
    int d0;
    do_clr();
    d0 = done_seen;
    send_frame(8, 0, 1'b0, seq_ctr++, 1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done_pulse got=%0d exp=1", done); end
    total++; if (last_len !== 16'(e_last_len)) begin bad++; $display("FAIL good_last_len got=%0d exp=%0d", last_len, e_last_len); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL good_cnt got=%0d exp=%0d", good_cnt, e_good); end
    total++; if (byte_cnt !== CW'(e_bytes)) begin bad++; $display("FAIL good_bytes got=%0d exp=%0d", byte_cnt, e_bytes); end
    idle(2);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_drop got=%0d exp=0", done); end
    total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL good_done_count got=%0d exp=1", done_seen - d0); end
  endtask

  task automatic test_runt_giant();
    do_clr();
    send_frame(8, 4, 1'b0, seq_ctr++, 1'b0);
    total++; if (last_len !== 16'd60) begin bad++; $display("FAIL runt_len got=%0d exp=60", last_len); end
    send_frame(190, 7, 1'b0, seq_ctr++, 1'b0);
    idle(1);
    total++; if (last_len !== 16'(e_last_len)) begin bad++; $display("FAIL giant_len got=%0d exp=%0d", last_len, e_last_len); end
    total++; if (runt_cnt !== CW'(e_runt)) begin bad++; $display("FAIL runt_cnt got=%0d exp=%0d", runt_cnt, e_runt); end
    total++; if (giant_cnt !== CW'(e_giant)) begin bad++; $display("FAIL giant_cnt got=%0d exp=%0d", giant_cnt, e_giant); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL rg_good got=%0d exp=%0d", good_cnt, e_good); end
    total++; if (byte_cnt !== CW'(e_bytes)) begin bad++; $display("FAIL rg_bytes got=%0d exp=%0d", byte_cnt, e_bytes); end
  endtask

  task automatic test_err_frame();
    do_clr();
    send_frame(13, 4, 1'b1, seq_ctr++, 1'b0);
    idle(1);
    total++; if (err_cnt !== CW'(e_err)) begin bad++; $display("FAIL err_cnt got=%0d exp=%0d", err_cnt, e_err); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL err_good got=%0d exp=%0d", good_cnt, e_good); end
    total++; if (last_len !== 16'd100) begin bad++; $display("FAIL err_len got=%0d exp=100", last_len); end
  endtask

  task automatic test_framing();
    do_clr();
    drive_word(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    e_frm++;
    idle(1);
    drive_word(1'b1, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    drive_word(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    drive_word(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    e_frm++;
    send_frame(8, 0, 1'b0, seq_ctr++, 1'b0);
    idle(1);
    total++; if (frm_err_cnt !== CW'(e_frm)) begin bad++; $display("FAIL frm_err_cnt got=%0d exp=%0d", frm_err_cnt, e_frm); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL frm_good got=%0d exp=%0d", good_cnt, e_good); end
    total++; if (byte_cnt !== CW'(e_bytes)) begin bad++; $display("FAIL frm_bytes got=%0d exp=%0d", byte_cnt, e_bytes); end
  endtask

  task automatic test_enable_drop();
    logic [63:0] d;
    logic [31:0] sq;
    do_clr();
    enable = 1'b1; avail = 1'b1;
    idle(2);
    total++; if (ren !== 1'b1) begin bad++; $display("FAIL en_ren_idle got=%0d exp=1", ren); end
    sq = seq_ctr++;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) enable = 1'b0;
      d = {$urandom, $urandom};
      if (i == 1) d[31:0] = sq;
      drive_word(i == 0, i == 9, 1'b0, 3'd0, d);
      total++; if (ren !== ((i < 9) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL en_ren_word%0d got=%0d exp=%0d", i, ren, (i < 9)); end
    end
    model_frame(10, 0, 1'b0, sq, 1'b0);
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL en_good got=%0d exp=%0d", good_cnt, e_good); end
    idle(2);
    total++; if (ren !== 1'b0) begin bad++; $display("FAIL en_ren_off got=%0d exp=0", ren); end
    enable = 1'b1;
    idle(1);
    total++; if (ren !== 1'b1) begin bad++; $display("FAIL en_ren_back got=%0d exp=1", ren); end
  endtask

  task automatic test_back_to_back();
    int d0, n, m;
    bit er;
    logic [31:0] sq;
    do_clr();
    d0 = done_seen;
    sq = seq_ctr;
    for (int f = 0; f < 40; f++) begin
      n  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 200);
      m  = $urandom_range(0, 7);
      er = ($urandom_range(0, 7) == 0);
      sq = ($urandom_range(0, 5) == 0) ? $urandom : sq + 32'd1;
      send_frame(n, m, er, sq, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    seq_ctr = sq + 32'd1;
    idle(1);
    total++; if (done_seen - d0 !== 40) begin bad++; $display("FAIL b2b_done got=%0d exp=40", done_seen - d0); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL b2b_good got=%0d exp=%0d", good_cnt, e_good); end
    total++; if (err_cnt !== CW'(e_err)) begin bad++; $display("FAIL b2b_err got=%0d exp=%0d", err_cnt, e_err); end
    total++; if (runt_cnt !== CW'(e_runt)) begin bad++; $display("FAIL b2b_runt got=%0d exp=%0d", runt_cnt, e_runt); end
    total++; if (giant_cnt !== CW'(e_giant)) begin bad++; $display("FAIL b2b_giant got=%0d exp=%0d", giant_cnt, e_giant); end
    total++; if (frm_err_cnt !== CW'(e_frm)) begin bad++; $display("FAIL b2b_frm got=%0d exp=%0d", frm_err_cnt, e_frm); end
    total++; if (seq_err_cnt !== CW'(e_seq)) begin bad++; $display("FAIL b2b_seq got=%0d exp=%0d", seq_err_cnt, e_seq); end
    total++; if (byte_cnt !== CW'(e_bytes)) begin bad++; $display("FAIL b2b_bytes got=%0d exp=%0d", byte_cnt, e_bytes); end
    total++; if (last_len !== 16'(e_last_len)) begin bad++; $display("FAIL b2b_last_len got=%0d exp=%0d", last_len, e_last_len); end
  endtask

  task automatic test_seq();
    logic [31:0] base;
    do_clr();
    base = 32'd5;
    send_frame(8, 0, 1'b0, base, 1'b0);
    send_frame(8, 0, 1'b0, base + 32'd1, 1'b0);
    send_frame(8, 0, 1'b0, base + 32'd3, 1'b0);
    send_frame(8, 0, 1'b0, base + 32'd4, 1'b0);
    send_frame(1, 0, 1'b0, 32'd0, 1'b0);
    idle(1);
    total++; if (seq_err_cnt !== CW'(e_seq)) begin bad++; $display("FAIL seq_err_cnt got=%0d exp=%0d", seq_err_cnt, e_seq); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL seq_good got=%0d exp=%0d", good_cnt, e_good); end
  endtask

  task automatic test_clr_with_eop();
    int d0;
    send_frame(8, 0, 1'b0, seq_ctr++, 1'b0);
    drive_word(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    e_frm++;
    d0 = done_seen;
    send_frame(20, 3, 1'b0, seq_ctr++, 1'b1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL clr_done got=%0d exp=1", done); end
    total++; if (last_len !== 16'(e_last_len)) begin bad++; $display("FAIL clr_last_len got=%0d exp=%0d", last_len, e_last_len); end
    total++; if ({good_cnt, err_cnt, runt_cnt, giant_cnt, frm_err_cnt, seq_err_cnt, byte_cnt} !== '0) begin
      bad++; $display("FAIL clr_counters got=%h exp=0", {good_cnt, err_cnt, runt_cnt, giant_cnt, frm_err_cnt, seq_err_cnt, byte_cnt});
    end
    idle(1);
    total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL clr_done_count got=%0d exp=1", done_seen - d0); end
  endtask

  task automatic test_saturation();
    do_clr();
    send_frame(8193, 0, 1'b0, seq_ctr++, 1'b0);
    total++; if (last_len !== 16'hFFFF) begin bad++; $display("FAIL sat_len got=%0d exp=65535", last_len); end
    total++; if (giant_cnt !== CW'(e_giant)) begin bad++; $display("FAIL sat_giant got=%0d exp=%0d", giant_cnt, e_giant); end
    send_frame(8, 0, 1'b0, seq_ctr++, 1'b0);
    idle(1);
    total++; if (byte_cnt !== CW'(CMAX)) begin bad++; $display("FAIL sat_bytes got=%0d exp=%0d", byte_cnt, CMAX); end
    total++; if (byte_cnt !== CW'(e_bytes)) begin bad++; $display("FAIL sat_bytes_model got=%0d exp=%0d", byte_cnt, e_bytes); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL sat_good got=%0d exp=%0d", good_cnt, e_good); end
  endtask

  task automatic test_reset_mid_frame();
    drive_word(1'b1, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    drive_word(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    reset = 1'b1;
    drive_word(1'b0, 1'b1, 1'b0, 3'd0, {$urandom, $urandom});
    reset = 1'b0;
    model_clr(); e_last_len = 0;
    total++; if ({good_cnt, byte_cnt, frm_err_cnt, last_len} !== '0) begin
      bad++; $display("FAIL rstmid_zero got=%h exp=0", {good_cnt, byte_cnt, frm_err_cnt, last_len});
    end
    send_frame(8, 0, 1'b0, seq_ctr++, 1'b0);
    idle(1);
    total++; if (frm_err_cnt !== CW'(e_frm)) begin bad++; $display("FAIL rstmid_frm got=%0d exp=%0d", frm_err_cnt, e_frm); end
    total++; if (good_cnt !== CW'(e_good)) begin bad++; $display("FAIL rstmid_good got=%0d exp=%0d", good_cnt, e_good); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clr_stats = 1'b0; avail = 1'b0;
    val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; mod = 3'd0; data = 64'd0;
    e_done = 0; e_last_len = 0; s_exp = 32'd0;
    model_clr();
    test_reset();
    test_good_frame();
    test_runt_giant();
    test_err_frame();
    test_framing();
    test_enable_drop();
    test_back_to_back();
    test_seq();
    test_clr_with_eop();
    test_saturation();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
